// File: rtl/lbdr_input_fifo.sv
// Per-port router input buffer: first-word-fall-through flit FIFO with credit return,
// write-side packet framing check and sticky overflow/protocol error flags.
module lbdr_input_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  read_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [2:0]            flit_id,
  output logic [3:0]            dst_addr,
  output logic                  empty,
  output logic                  full,
  output logic                  credit_out,
  output logic                  overflow_err,
  output logic                  proto_err
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  localparam logic [2:0] ID_HDR  = 3'b001;
  localparam logic [2:0] ID_BODY = 3'b010;
  localparam logic [2:0] ID_TAIL = 3'b100;

  typedef enum logic {IDLE, BUSY} state_t;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  credit_q, credit_d;
  logic                  overflow_q, overflow_d;
  logic                  proto_q, proto_d;
  state_t                state_q, state_d;
  logic                  rd_acc, wr_acc;
  logic [2:0]            in_id;

  assign in_id = data_in[DATA_WIDTH-1 -: 3];
  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));

  always_comb begin
    // A read frees a slot this cycle, so a full FIFO can still take a write.
    rd_acc     = read_en && !empty;
    wr_acc     = valid_in && (!full || rd_acc);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q + CNT_W'(wr_acc) - CNT_W'(rd_acc);
    credit_d   = rd_acc;
    overflow_d = overflow_q | (valid_in & ~wr_acc);
    proto_d    = proto_q;
    state_d    = state_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
    if (wr_acc) begin
      case (in_id)
        ID_HDR: begin
          if (state_q == BUSY) proto_d = 1'b1;
          state_d = BUSY;
        end
        ID_BODY: if (state_q == IDLE) proto_d = 1'b1;
        ID_TAIL: begin
          if (state_q == IDLE) proto_d = 1'b1;
          state_d = IDLE;
        end
        default: proto_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      credit_q   <= 1'b0;
      overflow_q <= 1'b0;
      proto_q    <= 1'b0;
      state_q    <= IDLE;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      credit_q   <= credit_d;
      overflow_q <= overflow_d;
      proto_q    <= proto_d;
      state_q    <= state_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= data_in;
  end

  assign data_out     = mem_q[rd_ptr_q];
  assign flit_id      = data_out[DATA_WIDTH-1 -: 3];
  assign dst_addr     = data_out[DATA_WIDTH-4 -: 4];
  assign credit_out   = credit_q;
  assign overflow_err = overflow_q;
  assign proto_err    = proto_q;
endmodule

// File: doc/lbdr_input_fifo.md
Name: lbdr_input_fifo

Overview:
- Per-port input buffer of the NoC router; sits directly upstream of LBDR.
- Stores incoming flits and presents the head flit first-word-fall-through, so LBDR sees empty, flit_id and dst_addr in the same cycle.
- Returns credits to the upstream router.
- Checks packet framing on the write side and flags overflow and protocol errors.

Parameters:
- DATA_WIDTH, 32: flit width. Bits [DATA_WIDTH-1:DATA_WIDTH-3] are flit_id. Bits [DATA_WIDTH-4:DATA_WIDTH-7] are dst_addr (valid in headers).
- DEPTH, 4: number of flit slots; power of two, >= 2.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- valid_in  input  1  upstream presents a flit this cycle.
- data_in  input  DATA_WIDTH  incoming flit.
- read_en  input  1  downstream pops the head flit (from the allocator after grant).
- data_out  output  DATA_WIDTH  head flit (combinational from storage).
- flit_id  output  3  head flit_id field.
- dst_addr  output  4  head dst_addr field.
- empty  output  1  no flits stored.
- full  output  1  DEPTH flits stored.
- credit_out  output  1  one-cycle pulse per popped flit.
- overflow_err  output  1  sticky; a write was dropped.
- proto_err  output  1  sticky; framing violation seen.

Behaviour:
- Reset (async assert, sync release): rd_ptr, wr_ptr and count = 0; empty=1, full=0, credit_out=0, overflow_err=0, proto_err=0, FSM=IDLE. Storage contents are not reset. data_out, flit_id and dst_addr equal the slot-0 contents and are don't-care while empty.
- Reset mid-packet discards all stored flits and returns the FSM to IDLE. No credits are issued for discarded flits.
- count width is clog2(DEPTH)+1. empty = (count==0); full = (count==DEPTH). Pointers wrap modulo DEPTH.
- Write accepted when valid_in=1 and (full=0 or a read is accepted in the same cycle). The flit is stored at wr_ptr and wr_ptr increments.
- valid_in=1 while full with no accepted read: flit dropped, overflow_err set; count and FSM unchanged.
- Read accepted when read_en=1 and empty=0. rd_ptr increments.
- read_en while empty is ignored: no credit, no error.
- Read and write in the same cycle:
  - When full: both accepted, count stays DEPTH.
  - When empty: only the write is accepted, and the head becomes visible the next cycle.
  - Otherwise: both accepted, count unchanged.
- Latency:
  - Flit written at edge N is visible on data_out after edge N if the FIFO was empty.
  - credit_out pulses high for exactly the cycle after each accepted read (registered).
  - Back-to-back reads give consecutive credit cycles.
- Framing FSM, evaluated on accepted writes only:
  - IDLE: header (001) -> BUSY.
  - BUSY: body (010) stays in BUSY; tail (100) -> IDLE.
  - Header-then-tail packets are legal.
- Violations, all of which set proto_err:
  - Body or tail in IDLE: state stays IDLE.
  - Header in BUSY: state stays BUSY, treated as a new packet.
  - Any other flit_id code: state unchanged.
  - In every violation case the flit is still stored.
- Dropped flits are not checked by the FSM.
- Error flags clear only on rst.

Test Plan:
- After reset, write 3 flits (H dst=4'b0110, B, T) with read_en=0 -> empty falls the cycle after the first write, flit_id=001, dst_addr=0110; count=3; full=0; no errors.
- Fill to 4 with read_en=0, then 1 more write -> full=1, 5th flit dropped, overflow_err=1, and 4 pops return the original 4 flits in order.
- Full FIFO, valid_in=1 and read_en=1 for 3 cycles -> full stays 1, 3 credit pulses each one cycle after a read, order preserved, no overflow.
- Empty FIFO, read_en=1 and valid_in=1 together -> no credit, flit stored, empty=0 next cycle; read_en alone on empty -> credit_out stays 0.
- Write body flit (010) first, then H-T, then H-H -> proto_err=1 after the first write. A clean H-B-T stream on a reset FIFO keeps proto_err=0.
- Mid-packet (after H,B), assert rst between clock edges -> empty=1 and credit_out=0 immediately. After release, a T-first write sets proto_err; H-T gives no error.
